// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - program counter sequencing controller
//
// Decides when the PC register updates and which next-PC source it takes.
// Handshakes with instruction memory, holds a returned instruction while
// decode stalls, and remembers branch/trap/mret redirect pulses until the
// next PC update consumes them.
//
// Optional feature macro: PC_SEQ_WATCHDOG_EN (fetch watchdog; without it
// WAIT holds indefinitely and fetch_timeout is tied low).
//
// Parameters:
//   BOOT_DELAY      cycles spent in BOOT after reset release (1..15)
//   TIMEOUT         WAIT cycles without a response before a fetch timeout (1..255)
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_req_ready  instruction memory accepts a request
//   imem_rsp_valid  instruction word returned (held by imem until consumed)
//   stall           decode cannot accept an instruction
//   pc_exc_en       misaligned-PC exception from the PC register
//   branch_req      branch/jump redirect pulse
//   trap_req        trap entry pulse
//   mret_req        mret pulse
//   imem_req_valid  fetch request for the current PC
//   pc_en           PC register update strobe
//   pc_branch_taken next-PC select: branch target
//   pc_trap_taken   next-PC select: trap vector
//   trap_done       next-PC select: mret return address
//   fetch_valid     returned instruction is on-path and consumed
//   flush           redirect applied, kill younger pipeline contents
//   fetch_timeout   1-cycle pulse on watchdog expiry

module pc_seq_ctrl #(
  parameter int unsigned BOOT_DELAY = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic imem_req_ready,
  input  logic imem_rsp_valid,
  input  logic stall,
  input  logic pc_exc_en,
  input  logic branch_req,
  input  logic trap_req,
  input  logic mret_req,
  output logic imem_req_valid,
  output logic pc_en,
  output logic pc_branch_taken,
  output logic pc_trap_taken,
  output logic trap_done,
  output logic fetch_valid,
  output logic flush,
  output logic fetch_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_DELAY);

  state_t     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic       br_p_q, br_p_d;
  logic       trap_p_q, trap_p_d;
  logic       mret_p_q, mret_p_d;

  logic rsp_live;     // response present and not marked for discard
  logic timeout;      // watchdog expiry this cycle
  logic rsp_take;     // response consumed by the PC update
  logic exc_take;     // misaligned-PC exception redirects to the trap vector
  logic force_trap;   // trap vector selected regardless of pending requests
  logic br_eff, trap_eff, mret_eff, redirect;

`ifdef PC_SEQ_WATCHDOG_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       drop_rsp_q, drop_rsp_d;

  always_comb begin
    rsp_live = imem_rsp_valid & ~drop_rsp_q;
    // The count equals the number of earlier empty WAIT cycles, so expiry
    // lands on the TIMEOUT-th empty WAIT cycle.
    timeout  = (state_q == ST_WAIT) & ~rsp_live & (wd_cnt_q == TIMEOUT_LAST);
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);

  always_comb begin
    rsp_live = imem_rsp_valid;
    timeout  = 1'b0;
  end
`endif

  // Datapath strobes, combinational so the PC register samples them on the
  // same edge the controller advances.
  always_comb begin
    rsp_take   = (state_q == ST_WAIT) & rsp_live & ~stall;
    exc_take   = (state_q == ST_FETCH) & pc_exc_en;
    force_trap = exc_take | timeout;

    br_eff   = br_p_q | branch_req;
    trap_eff = trap_p_q | trap_req;
    mret_eff = mret_p_q | mret_req;
    redirect = br_eff | trap_eff | mret_eff;

    imem_req_valid  = (state_q == ST_FETCH) & ~pc_exc_en;
    pc_en           = rsp_take | exc_take | timeout;
    trap_done       = pc_en & ~force_trap & mret_eff;
    pc_trap_taken   = pc_en & (force_trap | (trap_eff & ~mret_eff));
    pc_branch_taken = pc_en & ~force_trap & br_eff & ~trap_eff & ~mret_eff;
    flush           = pc_en & (redirect | timeout);
    fetch_valid     = pc_en & ~redirect & ~pc_exc_en & ~timeout;
    fetch_timeout   = timeout;
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q <= 4'd1) begin
          state_d = ST_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end
      ST_FETCH: begin
        // An exception consumes the cycle; fetch restarts from the trap PC.
        if (!pc_exc_en && imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeout || rsp_take) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Pending redirects: captured outside BOOT, consumed by any PC update.
  always_comb begin
    br_p_d   = br_p_q;
    trap_p_d = trap_p_q;
    mret_p_d = mret_p_q;
    if (pc_en) begin
      br_p_d   = 1'b0;
      trap_p_d = 1'b0;
      mret_p_d = 1'b0;
    end else if (state_q != ST_BOOT) begin
      br_p_d   = br_p_q | branch_req;
      trap_p_d = trap_p_q | trap_req;
      mret_p_d = mret_p_q | mret_req;
    end
  end

`ifdef PC_SEQ_WATCHDOG_EN
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d != ST_WAIT) begin
      wd_cnt_d = 8'd0;
    end else if ((state_q == ST_WAIT) && !rsp_live) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end

    // The abandoned request may still answer later; swallow exactly one
    // response wherever it shows up.
    drop_rsp_d = drop_rsp_q;
    if (timeout) begin
      drop_rsp_d = 1'b1;
    end else if (drop_rsp_q && imem_rsp_valid) begin
      drop_rsp_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      br_p_q     <= 1'b0;
      trap_p_q   <= 1'b0;
      mret_p_q   <= 1'b0;
`ifdef PC_SEQ_WATCHDOG_EN
      wd_cnt_q   <= 8'd0;
      drop_rsp_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      br_p_q     <= br_p_d;
      trap_p_q   <= trap_p_d;
      mret_p_q   <= mret_p_d;
`ifdef PC_SEQ_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      drop_rsp_q <= drop_rsp_d;
`endif
    end
  end

endmodule
